// File: rtl/isa_pkg.sv
// isa_pkg: RV64 subset encodings, loader FSM states and field-packing helpers.
package isa_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_ADDI, OP_LD, OP_SD, OP_BEQ
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_R};
  endfunction
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction
  // imm carries the byte offset bits [12:1]; bit 0 is implicit zero
  function automatic logic [31:0] enc_b(logic [12:1] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction
endpackage

// File: rtl/instr_encode.sv
// instr_encode: combinational packer from operation descriptor to 32-bit instruction word.
module instr_encode
  import isa_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        illegal
);
  always_comb begin
    word = '0;
    illegal = 1'b0;
    case (op_e'(op))
      OP_ADD:  word = enc_r(F7_BASE, rs2, rs1, F3_ADD, rd);
      OP_SUB:  word = enc_r(F7_SUB, rs2, rs1, F3_ADD, rd);
      OP_AND:  word = enc_r(F7_BASE, rs2, rs1, F3_AND, rd);
      OP_OR:   word = enc_r(F7_BASE, rs2, rs1, F3_OR, rd);
      OP_MUL:  word = enc_r(F7_MUL, rs2, rs1, F3_ADD, rd);
      OP_ADDI: word = enc_i(imm[11:0], rs1, F3_ADD, rd, OPC_I);
      OP_LD:   word = enc_i(imm[11:0], rs1, F3_D, rd, OPC_LOAD);
      OP_SD:   word = enc_s(imm[11:0], rs2, rs1, F3_D);
      OP_BEQ: begin
        word = enc_b(imm[12:1], rs2, rs1, F3_BEQ);
        illegal = imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: accepts descriptors, encodes them and writes consecutive instruction-memory words,
// then raises start_o for the CPU.
module instr_loader
  import isa_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int ADDR_W = 10,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [3:0]        op_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [12:0]       imm_i,
  input  logic              last_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              start_o,
  output logic [CW-1:0]     count_o,
  output logic              err_o
);
  state_e state, state_n;
  logic we, fin, fin_n, err, acc, open, illegal;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0] count;
  logic [CW:0] used;
  logic [31:0] data, word;

  instr_encode u_enc (
    .op(op_i), .rd(rd_i), .rs1(rs1_i), .rs2(rs2_i), .imm(imm_i),
    .word(word), .illegal(illegal)
  );

  // used counts the in-flight write so the DEPTH bound holds before it lands
  always_comb begin
    used = {1'b0, count} + {{CW{1'b0}}, we};
    ready_o = state == S_LOAD && !fin && used < (CW + 1)'(DEPTH);
    acc = valid_i && ready_o;
    fin_n = acc && !illegal && (last_i || used + (CW + 1)'(1) == (CW + 1)'(DEPTH));
    open = load_i && state != S_LOAD;
    state_n = open ? S_LOAD : (fin || (acc && illegal && last_i)) ? S_DONE : state;
  end

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= S_IDLE;
    else state <= state_n;

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      fin <= 1'b0;
      we <= 1'b0;
      data <= '0;
      addr <= '0;
      count <= '0;
      err <= 1'b0;
    end else begin
      fin <= fin_n;
      we <= acc && !illegal;
      if (acc && !illegal) data <= word;
      if (open) begin
        addr <= '0;
        count <= '0;
        err <= 1'b0;
      end else begin
        if (we) begin
          addr <= addr + ADDR_W'(4);
          count <= count + CW'(1);
        end
        if (acc && illegal) err <= 1'b1;
      end
    end

  assign imem_we_o = we;
  assign imem_addr_o = addr;
  assign imem_data_o = data;
  assign start_o = state == S_DONE;
  assign count_o = count;
  assign err_o = err;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed descriptors with hand-encoded expected writes checked by a scoreboard monitor.
module tb_instr_loader;
  logic clk = 0, rst_i = 0, load_i = 0, valid_i = 0, last_i = 0;
  logic [3:0] op_i = 0;
  logic [4:0] rd_i = 0, rs1_i = 0, rs2_i = 0;
  logic [12:0] imm_i = 0;
  logic ready_o, imem_we_o, start_o, err_o;
  logic [9:0] imem_addr_o;
  logic [31:0] imem_data_o;
  logic [2:0] count_o;
  int checks = 0, failures = 0;
  typedef struct {logic [9:0] a; logic [31:0] d;} wr_t;
  wr_t sb[$];

  always #5 clk = ~clk;

  instr_loader #(.DEPTH(4), .ADDR_W(10)) dut (
    .clk_i(clk), .rst_i(rst_i), .load_i(load_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .last_i(last_i),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
    .start_o(start_o), .count_o(count_o), .err_o(err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [9:0] a, input logic [31:0] d);
    sb.push_back('{a, d});
  endtask

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  // call at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [12:0] imm, input logic last);
    bit ok = 0;
    op_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm; last_i = last; valid_i = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1 valid_i = 0;
    last_i = 0;
  endtask

  task automatic pulse_load;
    sync;
    load_i = 1;
    sync;
    load_i = 0;
  endtask

  task automatic wait_start;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (start_o) break;
    end
    chk("start_rise", 32'(start_o), 32'd1);
  endtask

  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (imem_we_o) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr_o, imem_data_o);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 32'(imem_addr_o), 32'(e.a));
          chk("wr_data", imem_data_o, e.d);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready_o), 0);
    chk("rst_we", 32'(imem_we_o), 0);
    chk("rst_addr", 32'(imem_addr_o), 0);
    chk("rst_data", imem_data_o, 0);
    chk("rst_start", 32'(start_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_err", 32'(err_o), 0);
    sync;
    rst_i = 1;
    @(negedge clk);
    chk("idle_ready", 32'(ready_o), 0);
    // single ADD
    pulse_load;
    expect_wr(0, 32'h002081B3);
    send(0, 3, 1, 2, 0, 1);
    wait_start;
    chk("t1_count", 32'(count_o), 1);
    chk("t1_err", 32'(err_o), 0);
    // back-to-back I/L/S/B
    pulse_load;
    expect_wr(0, 32'hFFF00293);
    expect_wr(4, 32'h0100B203);
    expect_wr(8, 32'h0020B423);
    expect_wr(12, 32'hFE208EE3);
    send(5, 5, 0, 0, 13'h1FFF, 0);
    send(6, 4, 1, 0, 13'd16, 0);
    send(7, 0, 1, 2, 13'd8, 0);
    send(8, 0, 1, 2, 13'h1FFC, 1);
    @(negedge clk);
    chk("t2_no_start_during_write", 32'(start_o), 0);
    @(negedge clk);
    chk("t2_start", 32'(start_o), 1);
    chk("t2_count", 32'(count_o), 4);
    chk("t2_ready_done", 32'(ready_o), 0);
    // illegal descriptors skipped
    pulse_load;
    expect_wr(0, 32'h002081B3);
    send(0, 3, 1, 2, 0, 0);
    send(12, 3, 1, 2, 0, 0);
    send(8, 0, 1, 2, 13'd3, 0);
    expect_wr(4, 32'h022081B3);
    send(4, 3, 1, 2, 0, 1);
    @(negedge clk);
    chk("t3_err", 32'(err_o), 1);
    wait_start;
    chk("t3_count", 32'(count_o), 2);
    // DEPTH bound without last
    pulse_load;
    @(negedge clk);
    chk("t4_start_drop", 32'(start_o), 0);
    chk("t4_err_clear", 32'(err_o), 0);
    chk("t4_count_clear", 32'(count_o), 0);
    sync;
    for (int k = 1; k <= 4; k++) begin
      expect_wr(10'((k - 1) * 4), (32'(k) << 20) | (32'(k) << 7) | 32'h13);
      send(5, 5'(k), 0, 0, 13'(k), 0);
    end
    @(negedge clk);
    chk("t4_ready_full", 32'(ready_o), 0);
    sync;
    op_i = 0; valid_i = 1;
    wait_start;
    chk("t4_count", 32'(count_o), 4);
    chk("t4_ready_done", 32'(ready_o), 0);
    repeat (4) @(negedge clk);
    valid_i = 0;
    chk("t4_count_hold", 32'(count_o), 4);
    // reset while a write is pending
    pulse_load;
    send(0, 3, 1, 2, 0, 1);
    rst_i = 0;
    @(negedge clk);
    chk("t5_we", 32'(imem_we_o), 0);
    chk("t5_addr", 32'(imem_addr_o), 0);
    chk("t5_data", imem_data_o, 0);
    chk("t5_start", 32'(start_o), 0);
    chk("t5_count", 32'(count_o), 0);
    chk("t5_ready", 32'(ready_o), 0);
    sync;
    rst_i = 1;
    pulse_load;
    expect_wr(0, 32'h402081B3);
    expect_wr(4, 32'h0020F1B3);
    expect_wr(8, 32'h0020E1B3);
    send(1, 3, 1, 2, 0, 0);
    send(2, 3, 1, 2, 0, 0);
    send(3, 3, 1, 2, 0, 1);
    wait_start;
    chk("t5_count_after", 32'(count_o), 3);
    chk("t5_err_after", 32'(err_o), 0);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
# instr_loader

Sequential instruction encoder and loader that sits in front of the instruction memory and feeds the CPU. It accepts operation descriptors (operation, register indices, immediate) over a valid/ready handshake, packs each into a 32-bit RISC-V word (R-type add/sub/and/or/mul, addi, ld, sd, beq), and writes the words to consecutive instruction-memory addresses. When the program is loaded it raises `start_o`, which drives the CPU `start_i`.

## Interface
- `DEPTH`, 256: maximum number of words per load session.
- `ADDR_W`, 10: byte-address width of the memory write port; must satisfy 2^ADDR_W >= 4*DEPTH.
- `clk_i` input 1: single clock, rising edge.
- `rst_i` input 1: asynchronous, active-low reset.
- `load_i` input 1: one-cycle pulse that opens a load session.
- `valid_i` input 1: descriptor valid.
- `ready_o` output 1: descriptor accepted when `valid_i && ready_o` at a rising edge.
- `op_i` input 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 ADDI, 6 LD, 7 SD, 8 BEQ; 9-15 illegal.
- `rd_i`, `rs1_i`, `rs2_i` input 5 each: register indices; unused fields are ignored.
- `imm_i` input 13: signed immediate. I/S-type use [11:0]. BEQ uses [12:1] as a byte offset, and `imm_i[0]` must be 0.
- `last_i` input 1: marks the final descriptor of the program.
- `imem_we_o` output 1: memory write strobe.
- `imem_addr_o` output ADDR_W: byte address.
- `imem_data_o` output 32: encoded word.
- `start_o` output 1: program loaded; CPU may run.
- `count_o` output $clog2(DEPTH+1): number of words written this session.
- `err_o` output 1: sticky illegal-descriptor flag.

## Operation
- FSM states: IDLE, LOAD, DONE. Reset puts the FSM in IDLE.
- IDLE:
  - `ready_o`=0.
  - On `load_i` -> LOAD; clear the address, `count_o` and `err_o`.
- LOAD:
  - `ready_o`=1 while `count_o` + (write pending) < DEPTH.
  - Each accepted legal descriptor is encoded and registered, then written on the next cycle. After the write, the address increments by 4 and the count by 1.
  - Illegal descriptor (op 9-15, or BEQ with `imm_i[0]`=1): the handshake completes, no write is issued, the address is not advanced, and `err_o` is set.
  - Accept with `last_i`=1, or the accept that makes the word total DEPTH: -> DONE once the final write (if any) has completed.
- DONE:
  - `start_o`=1 and `ready_o`=0.
  - `load_i` -> LOAD: `start_o` drops the same edge; address, count and `err_o` are cleared.
- `load_i` in LOAD: ignored.
- Encodings:
  - R-type: opcode 0110011, funct3 000/000/111/110/000, funct7 0000000/0100000/0000000/0000000/0000001.
  - ADDI: opcode 0010011, funct3 000.
  - LD: opcode 0000011, funct3 011.
  - SD: opcode 0100011, funct3 011.
  - BEQ: opcode 1100011, funct3 000, standard B-type immediate scatter.
- Address arithmetic is modulo 2^ADDR_W. The DEPTH bound prevents wrap inside a session.

## Timing
- Reset values: `ready_o`=0, `imem_we_o`=0, `imem_addr_o`=0, `imem_data_o`=0, `start_o`=0, `count_o`=0, `err_o`=0.
- Latency: accept edge N -> `imem_we_o`=1 with data and address during cycle N+1. Throughput is 1 word per cycle.
- `start_o` rises the cycle after the last write cycle. If the last descriptor is illegal, it rises the cycle after that accept.
- `imem_we_o` is a single-cycle pulse per word. Address and data are valid only while `imem_we_o`=1.
- Reset mid-session: all state returns to reset values immediately. A pending write is dropped.
- `load_i` is only sampled in IDLE and DONE.

## Structure
- Shared package `isa_pkg`:
  - op enum.
  - opcode constants for R, I, LOAD, STORE, BRANCH.
  - funct3/funct7 constants.
  - immediate-scatter helper functions for I, S and B types.
- Sub-module `instr_encode`: combinational field packer (descriptor -> 32-bit word + illegal flag). The top level holds the FSM, output register, address and counter.

## Test plan
- After reset, `load_i`, then ADD rd=3 rs1=1 rs2=2 -> one write of 0x002081B3 at address 0. `count_o`=1.
- Back-to-back descriptors in consecutive cycles:
  - ADDI rd=5 rs1=0 imm=-1 -> 0xFFF00293 @0
  - LD rd=4 rs1=1 imm=16 -> 0x0100B203 @4
  - SD rs1=1 rs2=2 imm=8 -> 0x0020B423 @8
  - BEQ rs1=1 rs2=2 imm=-4, `last_i` -> 0xFE208EE3 @12
  - Then `start_o`=1 one cycle after the last write, with `count_o`=4.
- Program ADD, op=12, MUL rd=3 rs1=1 rs2=2 with `last_i`:
  - `err_o`=1.
  - Writes 0x002081B3 @0 and 0x022081B3 @4 only.
  - `count_o`=2.
- DEPTH=4, feed 6 descriptors without `last_i` -> 4 writes, `ready_o` low after the 4th accept, DONE, and `start_o`=1.
- Assert `rst_i`=0 during the cycle a write is pending -> no write, all outputs at reset values. A subsequent `load_i` restarts at address 0.
- In DONE, pulse `load_i` -> `start_o`=0 the next cycle. The next descriptor is written at address 0 and `err_o` is cleared.
